// File: rtl/prog_divider_pkg.sv
// prog_divider_pkg
// Shared types, limits and helpers for the programmable divider.
//   chan_cmd_e      : per-cycle action decoded from sync/enable/counter state
//   reload_value()  : counter value loaded at the terminal cycle, max(D,1)-1
package prog_divider_pkg;

`include "prog_divider_util.svh"

  localparam int PD_CHANNELS_MIN = `PD_CHANNELS_MIN;
  localparam int PD_CHANNELS_MAX = `PD_CHANNELS_MAX;
  localparam int PD_WIDTH_MIN    = `PD_WIDTH_MIN;
  localparam int PD_WIDTH_MAX    = `PD_WIDTH_MAX;

  typedef enum logic [1:0] {
    CMD_HOLD    = 2'd0,  // enable low: freeze count and square
    CMD_RESTART = 2'd1,  // sync: clear count and square
    CMD_RELOAD  = 2'd2,  // terminal cycle: pulse, toggle, load next period
    CMD_COUNT   = 2'd3   // mid-period: decrement
  } chan_cmd_e;

  // D=0 and D=1 both reload 0 so the channel fires on every enabled cycle.
  function automatic logic [PD_WIDTH_MAX-1:0] reload_value(
    input logic [PD_WIDTH_MAX-1:0] d
  );
    return (d == '0) ? '0 : d - 16'd1;
  endfunction

endpackage

// File: rtl/prog_divider_channel.sv
// divider_channel
// One independent divider: WIDTH-bit down-counter with a registered
// one-cycle pulse at each terminal count and a registered square output
// that toggles on each pulse (period 2*D).
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   divisor    : period D, sampled only when the counter reloads
//   enable     : count enable; low freezes the channel
//   sync       : restart strobe; clears count and square, beats enable
//   pulse      : registered tick, one per period
//   square     : registered toggle output
module divider_channel
  import prog_divider_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] divisor,
  input  logic             enable,
  input  logic             sync,
  output logic             pulse,
  output logic             square
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             square_q, square_d;
  chan_cmd_e        cmd;

  // sync outranks enable, which outranks the reload/decrement choice.
  always_comb begin
    cmd = CMD_HOLD;
    if (sync)               cmd = CMD_RESTART;
    else if (!enable)       cmd = CMD_HOLD;
    else if (cnt_q == '0)   cmd = CMD_RELOAD;
    else                    cmd = CMD_COUNT;
  end

  always_comb begin
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    square_d = square_q;
    unique case (cmd)
      CMD_RESTART: begin
        cnt_d    = '0;
        square_d = 1'b0;
      end
      CMD_RELOAD: begin
        // Divisor is looked at only here, so a mid-period change never
        // shortens the period already in flight.
        cnt_d    = WIDTH'(reload_value(PD_WIDTH_MAX'(divisor)));
        pulse_d  = 1'b1;
        square_d = ~square_q;
      end
      CMD_COUNT: begin
        cnt_d = cnt_q - ONE;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      square_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      square_q <= square_d;
    end
  end

  assign pulse  = pulse_q;
  assign square = square_q;

endmodule

// File: rtl/prog_divider_util.svh
// prog_divider_util.svh
// Shared helper macros for the programmable divider: a constant-expression
// ceil(log2) and the legal parameter ranges for channel count and counter
// width. Guarded so several files can include it safely.
`ifndef PROG_DIVIDER_UTIL_SVH
`define PROG_DIVIDER_UTIL_SVH

// ceil(log2(x)) usable in parameter/localparam expressions, valid up to 2^16.
`define PD_CLOG2(x) \
  (((x) <= 1)     ? 0  : ((x) <= 2)     ? 1  : ((x) <= 4)     ? 2  : \
   ((x) <= 8)     ? 3  : ((x) <= 16)    ? 4  : ((x) <= 32)    ? 5  : \
   ((x) <= 64)    ? 6  : ((x) <= 128)   ? 7  : ((x) <= 256)   ? 8  : \
   ((x) <= 512)   ? 9  : ((x) <= 1024)  ? 10 : ((x) <= 2048)  ? 11 : \
   ((x) <= 4096)  ? 12 : ((x) <= 8192)  ? 13 : ((x) <= 16384) ? 14 : \
   ((x) <= 32768) ? 15 : 16)

`define PD_CHANNELS_MIN 1
`define PD_CHANNELS_MAX 8
`define PD_WIDTH_MIN    2
`define PD_WIDTH_MAX    16

`endif

// File: rtl/prog_divider.sv
// prog_divider
// Bank of CHANNELS fully independent programmable dividers.
// Ports:
//   clk     : sole clock, rising edge
//   reset   : synchronous active-high reset, overrides every other input
//   divisor : per-channel period, channel i at [i*WIDTH +: WIDTH]
//   enable  : per-channel count enable
//   sync    : per-channel restart strobe
//   pulse   : per-channel registered one-cycle tick per period
//   square  : per-channel registered toggle output, period 2*D
module prog_divider
  import prog_divider_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] divisor,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       sync,
  output logic [CHANNELS-1:0]       pulse,
  output logic [CHANNELS-1:0]       square
);

  if (CHANNELS < PD_CHANNELS_MIN || CHANNELS > PD_CHANNELS_MAX ||
      WIDTH < PD_WIDTH_MIN || WIDTH > PD_WIDTH_MAX) begin : g_bad_params
    $error("prog_divider: CHANNELS or WIDTH out of supported range");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    divider_channel #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .divisor(divisor[i*WIDTH +: WIDTH]),
      .enable (enable[i]),
      .sync   (sync[i]),
      .pulse  (pulse[i]),
      .square (square[i])
    );
  end

endmodule

// File: doc/prog_divider.md
PROG_DIVIDER -- requirements
Module: prog_divider

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, meaning number of independent divider channels (1..8).
REQ-002 SHALL have parameter WIDTH, default 16, meaning divisor/counter width per channel in bits (2..16).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port divisor  input  CHANNELS*WIDTH  per-channel period D; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port enable  input  CHANNELS  per-channel count enable; low freezes that channel.
REQ-007 SHALL have port sync  input  CHANNELS  per-channel restart strobe.
REQ-008 SHALL have port pulse  output  CHANNELS  registered one-cycle tick per period.
REQ-009 SHALL have port square  output  CHANNELS  registered toggle output, period 2*D.

Function
REQ-010 Channels SHALL be fully independent; no shared counter state.
REQ-011 Each channel SHALL hold a WIDTH-bit down-counter cnt.
REQ-012 Cycle with enable=1, sync=0, cnt==0: next cycle pulse=1, square toggles, cnt loads max(D,1)-1.
REQ-013 Cycle with enable=1, sync=0, cnt!=0: next cycle pulse=0, cnt decrements by 1, square holds.
REQ-014 Steady-state pulse period SHALL be exactly D cycles for D>=2; D=0 and D=1 SHALL both give pulse held high every enabled cycle.
REQ-015 divisor SHALL be sampled only at reload (cnt==0 event); changes mid-period SHALL take effect from the next period, never truncate the current one.
REQ-016 enable=0: cnt holds, pulse=0 next cycle, square holds; resuming continues the interrupted period with no lost or extra cycle.
REQ-017 sync=1 (regardless of enable): cnt forced to 0, pulse=0 next cycle, square forced to 0; first pulse then follows the first enabled cycle after sync drops.
REQ-018 sync SHALL take priority over enable and reload when simultaneous.
REQ-019 Latency from terminal cycle to pulse SHALL be exactly 1 clock; pulse SHALL never be high two consecutive cycles unless D<=1.
REQ-020 Counter arithmetic SHALL be WIDTH bits, no wrap below 0 (decrement only when cnt!=0); D=2^WIDTH-1 SHALL be the maximum period.

Reset
REQ-021 reset SHALL override all inputs including sync.
REQ-022 In reset cycle and after: cnt=0, pulse=0, square=0 for every channel.
REQ-023 First pulse after reset release SHALL appear the cycle after the first enabled cycle (cnt==0 already).
REQ-024 Reset asserted mid-period SHALL discard the partial count; no pulse in the cycle after reset.

Structure
REQ-025 The CLOG2-style width macro and WIDTH/CHANNELS limits SHALL live in the shared util header, guarded against double inclusion.
REQ-026 One sub-module divider_channel (single counter, pulse, square) SHALL be instantiated CHANNELS times via generate.
REQ-027 No combinational path from any input to pulse or square.

Verification
REQ-028 reset, then enable=1, D=4 -> pulse high cycles 1,5,9,13 after release; square toggles at each.
REQ-029 D=1 then D=0 on ch0, enable=1 -> pulse high every cycle; square toggles every cycle.
REQ-030 D=5, change to D=3 two cycles after a pulse -> next gap remains 5, following gaps 3.
REQ-031 D=6, drop enable for 3 cycles mid-period -> pulse gap 9 once, square unchanged during pause, then gaps 6.
REQ-032 ch0 D=3, ch1 D=7, sync ch1 mid-period with enable=1 -> ch0 unaffected; ch1 square=0, next ch1 pulse 2 cycles after sync drops, then gap 7.
REQ-033 D=0xFFFF, WIDTH=16, reset asserted at count 100 -> outputs 0, no pulse next cycle, first pulse the cycle after the first enabled cycle post-release.
